// File: rtl/mul_booth_iter_if.sv
// Request/response bundle for the iterative Booth multiplier.
// The producer side drives operands and flush; the multiplier side answers.
interface mul_booth_iter_if #(
    parameter int XLEN = 64
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      mul_op;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;

    modport master (
        output flush, in_valid, mul_op, src1, src2, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  flush, in_valid, mul_op, src1, src2, out_ready,
        output in_ready, out_valid, result
    );
endinterface

// File: rtl/mul_booth_iter.sv
// Iterative radix-4 Booth multiplier: two digits per cycle through a 4:2
// compressor, then one carry-propagate add. Handles MUL/MULH/MULHSU/MULHU.
module compressor_42 #(
    parameter int W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [W-1:0] c_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] sum_o,
    output logic [W-1:0] carry_o
);
    logic [W-1:0] s1;
    logic [W-1:0] c1;

    assign s1      = a_i ^ b_i ^ c_i;
    assign c1      = ((a_i & b_i) | (a_i & c_i) | (b_i & c_i)) << 1;
    assign sum_o   = s1 ^ c1 ^ d_i;
    assign carry_o = ((s1 & c1) | (s1 & d_i) | (c1 & d_i)) << 1;
endmodule

module mul_booth_iter #(
    parameter int XLEN = 64
) (
    input logic              clk,
    input logic              rst_n,
    mul_booth_iter_if.slave  bus
);
    localparam int W  = 2*XLEN + 4;
    localparam int D  = (XLEN + 2) / 2;
    localparam int N  = (D + 1) / 2;
    localparam int MW = XLEN + 2;
    localparam int IW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        ADD,
        DONE
    } state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    mcand_q, mcand_d;
    logic [W-1:0]    nmcand_q, nmcand_d;
    logic [W-1:0]    sum_q, sum_d;
    logic [W-1:0]    carry_q, carry_d;
    logic [MW-1:0]   mplr_q, mplr_d;
    logic            bm1_q, bm1_d;
    logic [IW-1:0]   iter_q, iter_d;
    logic [1:0]      op_q, op_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            out_valid_q, out_valid_d;

    logic [W-1:0]      pp0, pp1;
    logic [W-1:0]      cs_sum, cs_carry;
    logic [W-1:0]      ext1;
    logic [MW-1:0]     ext2;
    logic [2*XLEN-1:0] prod;
    logic              sx1, sx2;

    function automatic logic [W-1:0] booth_pp(
        input logic [2:0]   g,
        input logic [W-1:0] m,
        input logic [W-1:0] nm
    );
        case (g)
            3'b001, 3'b010: booth_pp = m;
            3'b011:         booth_pp = m << 1;
            3'b100:         booth_pp = nm << 1;
            3'b101, 3'b110: booth_pp = nm;
            default:        booth_pp = '0;
        endcase
    endfunction

    assign pp0 = booth_pp({mplr_q[1:0], bm1_q}, mcand_q, nmcand_q);
    assign pp1 = booth_pp(mplr_q[3:1], mcand_q, nmcand_q) << 2;

    compressor_42 #(.W(W)) u_csa (
        .a_i    (pp0),
        .b_i    (pp1),
        .c_i    (sum_q),
        .d_i    (carry_q),
        .sum_o  (cs_sum),
        .carry_o(cs_carry)
    );

    // MULH and MULHSU treat src1 as signed; only MULH treats src2 as signed.
    assign sx1  = (bus.mul_op == 2'b01) || (bus.mul_op == 2'b10);
    assign sx2  = (bus.mul_op == 2'b01);
    assign ext1 = {{(W-XLEN){sx1 & bus.src1[XLEN-1]}}, bus.src1};
    assign ext2 = {{2{sx2 & bus.src2[XLEN-1]}}, bus.src2};
    assign prod = sum_q[2*XLEN-1:0] + carry_q[2*XLEN-1:0];

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mcand_q     <= '0;
            nmcand_q    <= '0;
            sum_q       <= '0;
            carry_q     <= '0;
            mplr_q      <= '0;
            bm1_q       <= 1'b0;
            iter_q      <= '0;
            op_q        <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mcand_q     <= mcand_d;
            nmcand_q    <= nmcand_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            mplr_q      <= mplr_d;
            bm1_q       <= bm1_d;
            iter_q      <= iter_d;
            op_q        <= op_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        mcand_d     = mcand_q;
        nmcand_d    = nmcand_q;
        sum_d       = sum_q;
        carry_d     = carry_q;
        mplr_d      = mplr_q;
        bm1_d       = bm1_q;
        iter_d      = iter_q;
        op_d        = op_q;
        result_d    = result_q;
        out_valid_d = out_valid_q;

        if (bus.flush) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            iter_d      = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        state_d  = CALC;
                        mcand_d  = ext1;
                        nmcand_d = '0 - ext1;
                        mplr_d   = ext2;
                        bm1_d    = 1'b0;
                        sum_d    = '0;
                        carry_d  = '0;
                        iter_d   = '0;
                        op_d     = bus.mul_op;
                    end
                end
                CALC: begin
                    sum_d    = cs_sum;
                    carry_d  = cs_carry;
                    mcand_d  = mcand_q << 4;
                    nmcand_d = nmcand_q << 4;
                    // Arithmetic shift: surplus top digits decode to zero.
                    mplr_d   = {{4{mplr_q[MW-1]}}, mplr_q[MW-1:4]};
                    bm1_d    = mplr_q[3];
                    iter_d   = iter_q + 1'b1;
                    if (iter_q == IW'(N - 1)) begin
                        state_d = ADD;
                    end
                end
                ADD: begin
                    if (op_q == 2'b00) begin
                        result_d = prod[XLEN-1:0];
                    end else begin
                        result_d = prod[2*XLEN-1:XLEN];
                    end
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_d = 1'b0;
                        state_d     = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end
endmodule

// File: doc/mul_booth_iter.md
Name: mul_booth_iter

Overview:
- Iterative radix-4 Booth multiplier for the execution unit.
- Each cycle it retires two Booth digits. The two partial products, plus the running sum/carry accumulator, are reduced by one compressor_42 instance (4 inputs -> sum + carry).
- A final carry-propagate add produces the product.
- Supports the RISC-V MUL/MULH/MULHSU/MULHU modes behind a valid/ready handshake with flush.

Parameters:
XLEN, 64, operand/result width; must be even and >= 8
W (local), 2*XLEN+4, internal accumulator width
D (local), (XLEN+2)/2, Booth digit count
N (local), ceil(D/2), CALC iterations

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous kill of any operation in flight
in_valid  input  1  operands valid
in_ready  output  1  block can accept; high only in IDLE
mul_op  input  2  00 MUL (low, ss); 01 MULH (high, ss); 10 MULHSU (high, src1 signed, src2 unsigned); 11 MULHU (high, uu)
src1  input  XLEN  multiplicand
src2  input  XLEN  multiplier
out_valid  output  1  result valid; high only in DONE
out_ready  input  1  consumer accepts result
result  output  XLEN  selected product half

Behaviour:
- Reset (async, rst_n=0): state=IDLE, out_valid=0, result=0, all datapath registers 0. in_ready is decoded from state, so it is 1 while in reset.
- States: IDLE, CALC, ADD, DONE.
- IDLE:
  - On in_valid&in_ready at edge E0, latch operands and go to CALC with iter=0.
  - mcand = src1 extended to W bits: sign-extended if mul_op is 01 or 10, else zero-extended.
  - neg_mcand = -mcand mod 2^W.
  - mplr = src2 extended to XLEN+2 bits: sign-extended if mul_op=01, else zero-extended. Booth bit b[-1]=0.
  - sum=0, carry=0.
- CALC, each edge:
  - Booth digits from mplr bits [1:-1] and [3:1] select PP0 and PP1 from {0, +m, +2m, -m, -2m} of the current (mcand, neg_mcand).
  - PP1 is additionally shifted left by 2.
  - compressor_42(PP0, PP1, sum, carry) -> new sum, new carry. The carry output is truncated to W bits; all arithmetic is mod 2^W.
  - mcand and neg_mcand shift left by 4.
  - mplr shifts right arithmetically by 4, with the old bit 3 retained as the next b[-1].
  - iter increments.
  - After iteration N-1, go to ADD. Digits beyond D evaluate to 0 through the arithmetic shift.
- ADD, one edge:
  - prod = (sum + carry)[2*XLEN-1:0].
  - result = prod[XLEN-1:0] for MUL, else prod[2*XLEN-1:XLEN].
  - out_valid <= 1; go to DONE.
- DONE:
  - result and out_valid hold until out_ready=1.
  - On that edge: out_valid <= 0, go to IDLE.
  - in_ready=0, so no same-cycle accept.
- Latency: out_valid is high starting N+1 edges after the accept edge E0. For XLEN=64: N=17, latency 18. For XLEN=32: N=9, latency 10.
- flush:
  - Highest priority, in any state.
  - Next edge: state=IDLE, out_valid=0, iter=0, result unchanged.
  - in_valid in the same cycle as flush is not accepted.
- Operands are sampled only at the accept edge. Later changes on src1/src2/mul_op have no effect.
- Async reset mid-CALC or DONE aborts immediately. No stale out_valid after release.
- Simultaneous flush and out_ready in DONE: the flush path is taken; the result is discarded.

Test Plan:
(XLEN=32 unless noted)
- MUL src1=7, src2=6, out_ready=1 -> result=0x0000002A; out_valid high exactly 10 cycles after accept, for 1 cycle; in_ready low throughout.
- MULH 0x80000000*0x80000000 -> 0x40000000; MUL same operands -> 0x00000000; MULH 0xFFFFFFFF*0x00000002 -> 0xFFFFFFFF.
- MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU src1=0xFFFFFFFF, src2=0xFFFFFFFF -> 0xFFFFFFFF; MUL same -> 0x00000001.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> result stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next cycle; back-to-back op then returns its correct result.
- flush at CALC iteration 4 -> IDLE next edge, out_valid never asserts; a following MULHU 0x12345678*0x9ABCDEF0 -> 0x0B00EA4E. rst_n pulsed low mid-CALC -> out_valid=0 and in_ready=1 during reset.
- XLEN=64 random sweep, 10k ops over all mul_op values against a 128-bit golden model -> zero mismatches; latency 18 on every op.
